// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache between fetch and the
// memory controller's instruction port; misses stall in FETCH until iwait drops.
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [31:0]        r_miss_addr;
    logic [31:0]        r_miss_count;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_fill;
    logic               w_capture;
    logic               w_unused_bits;

    assign w_idx         = imemaddr[IDX_W+1:2];
    assign w_tag         = imemaddr[31:IDX_W+2];
    assign w_fill_idx    = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag    = r_miss_addr[31:IDX_W+2];
    assign w_unused_bits = ^imemaddr[1:0];
    assign w_hit         = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_fill        = (r_state == FETCH) & ~iwait;
    assign miss_count    = r_miss_count;

    // State register; reset aborts any fill in flight and drops iREN at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lookup result, memory request and next state.
    always_comb begin
        w_next_state = r_state;
        ihit         = 1'b0;
        imemload     = 32'h0000_0000;
        iREN         = 1'b0;
        iaddr        = 32'h0000_0000;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                ihit     = w_hit;
                imemload = w_hit ? r_data[w_idx] : 32'h0000_0000;
                if (imemREN && !w_hit) begin
                    w_capture    = 1'b1;
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = r_miss_addr;
                if (!iwait) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Miss address latch, valid bits and saturating miss counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_miss_addr  <= 32'h0000_0000;
            r_miss_count <= 32'h0000_0000;
            r_valid      <= '0;
        end else begin
            if (w_capture) begin
                r_miss_addr <= {imemaddr[31:2], 2'b00};
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
                if (r_miss_count != 32'hFFFF_FFFF) begin
                    r_miss_count <= r_miss_count + 32'd1;
                end
            end
        end
    end

    // Tag/data arrays need no reset: valid bits gate every lookup.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

endmodule
